// File: rtl/console_fanout.sv
// Console byte distributor: DEPTH-entry FIFO broadcasting each byte
// to NCH sinks, with per-sink timeout isolation and drop counting.
module console_fanout #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstin,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_bits,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    out_val,
  input  logic [NCH-1:0]    out_rdy,
  output logic [DATA_W-1:0] out_bits,
  output logic [NCH-1:0]    stalled,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_EMPTY,
    S_PRESENT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [NCH-1:0]    pending;
  logic [31:0]       timer;

  logic           push;
  logic           pres;
  logic           null_hd;
  logic           tmo;
  logic           pop;
  logic           load;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] stl_nxt;
  logic [LW-1:0]  lvl_nxt;

  assign in_rdy   = rstin & (level != LW'(DEPTH));
  assign push     = in_val & in_rdy;
  assign out_val  = pending;
  assign out_bits = mem[rd_ptr];

  always_comb begin
    pres     = (state == S_PRESENT);
    fire     = pending & out_rdy;
    pend_nxt = pending & ch_en & ~stalled & ~fire;
    null_hd  = pres & (pending == '0);
    tmo      = (TIMEOUT != 0) & pres & (pending != '0)
             & (timer == 32'(TIMEOUT - 1)) & (pend_nxt != '0);
    pop      = pres & ((pend_nxt == '0) | tmo);
    lvl_nxt  = level + LW'(push) - LW'(pop);
    load     = (lvl_nxt != '0) & (~pres | pop);
    // a sink timing out now is already masked from the next head
    stl_nxt  = (stalled | (tmo ? pend_nxt : '0)) & ch_en;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bits;
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state    <= S_EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pending  <= '0;
      timer    <= '0;
      stalled  <= '0;
      drop_cnt <= '0;
    end else begin
      level   <= lvl_nxt;
      stalled <= stl_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (null_hd && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (load) begin
        state   <= S_PRESENT;
        pending <= ch_en & ~stl_nxt;
        timer   <= '0;
      end else if (pop) begin
        state   <= S_EMPTY;
        pending <= '0;
      end else begin
        pending <= pend_nxt;
        if (pending != '0) timer <= timer + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_console_fanout.sv
// Scoreboard bench for console_fanout: per-sink expected byte queues
// filled on accepted pushes and drained on sink handshakes.
module tb_console_fanout;

  localparam int NCH = 3;
  localparam int DEPTH = 16;
  localparam int TMO = 32;

  logic       clk = 0;
  logic       rstin = 0;
  logic       in_val = 0;
  logic       in_rdy;
  logic [7:0] in_bits = 0;
  logic [2:0] ch_en = 0;
  logic [2:0] out_val;
  logic [2:0] out_rdy = 0;
  logic [7:0] out_bits;
  logic [2:0] stalled;
  logic [4:0] level;
  logic [15:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_mask = 0;
  logic [7:0] sq [NCH][$];
  logic [7:0] mon_exp;

  console_fanout #(
    .DATA_W(8), .DEPTH(DEPTH), .NCH(NCH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstin(rstin),
    .in_val(in_val), .in_rdy(in_rdy), .in_bits(in_bits),
    .ch_en(ch_en), .out_val(out_val), .out_rdy(out_rdy),
    .out_bits(out_bits), .stalled(stalled),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstin) begin
      if (in_val && in_rdy)
        for (int i = 0; i < NCH; i++)
          if (exp_mask[i]) sq[i].push_back(in_bits);
      for (int i = 0; i < NCH; i++) begin
        if (out_val[i] && out_rdy[i]) begin
          vectors++;
          if (sq[i].size() == 0) begin
            miscompares++;
            $display("FAIL sink%0d_extra got %h required none",
                     i, out_bits);
          end else begin
            mon_exp = sq[i].pop_front();
            if (out_bits !== mon_exp) begin
              miscompares++;
              $display("FAIL sink%0d_data got %h required %h",
                       i, out_bits, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (level == 0 && out_val == 0) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout got level %0d required 0", level);
    end
    for (int i = 0; i < NCH; i++) begin
      vectors++;
      if (sq[i].size() != 0) begin
        miscompares++;
        $display("FAIL drain_q%0d got %0d left required 0",
                 i, sq[i].size());
      end
    end
    cyc();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({level, out_val, stalled, drop_cnt, in_rdy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got lvl %0d val %b stl %b drop %0d rdy %b required all 0",
               level, out_val, stalled, drop_cnt, in_rdy);
    end
    cyc();
    rstin = 1;
    @(negedge clk);
    vectors++;
    if (in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_rdy got %b required 1", in_rdy);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    ch_en = 3'b111;
    out_rdy = 3'b111;
    exp_mask = 3'b111;
    in_val = 1;
    in_bits = 8'h41;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_latency got %b required 000", out_val);
    end
    cyc();
    in_bits = 8'h42;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b111 || out_bits !== 8'h41) begin
      miscompares++;
      $display("FAIL b2b_first got %b/%h required 111/41", out_val, out_bits);
    end
    cyc();
    in_val = 0;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b111 || out_bits !== 8'h42) begin
      miscompares++;
      $display("FAIL b2b_second got %b/%h required 111/42", out_val, out_bits);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (level !== 5'd0 || out_val !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_end got lvl %0d val %b required 0/000", level, out_val);
    end
    cyc();
  endtask

  task automatic test_slow_sink();
    out_rdy = 3'b101;
    in_val = 1;
    in_bits = 8'h41;
    cyc();
    in_val = 0;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b111 || level !== 5'd1) begin
      miscompares++;
      $display("FAIL slow_present got %b lvl %0d required 111 lvl 1", out_val, level);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b010) begin
      miscompares++;
      $display("FAIL slow_partial got %b required 010", out_val);
    end
    repeat (3) cyc();
    out_rdy = 3'b111;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b010 || level !== 5'd1) begin
      miscompares++;
      $display("FAIL slow_held got %b lvl %0d required 010 lvl 1", out_val, level);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b000 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL slow_pop got %b lvl %0d required 000 lvl 0", out_val, level);
    end
    cyc();
  endtask

  task automatic test_full();
    bit took = 0;
    out_rdy = 3'b000;
    for (int i = 0; i < DEPTH; i++) begin
      in_val = 1;
      in_bits = 8'h60 + 8'(i);
      cyc();
    end
    in_bits = 8'h70;
    @(negedge clk);
    vectors++;
    if (level !== 5'd16 || in_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state got lvl %0d rdy %b required 16/0", level, in_rdy);
    end
    cyc();
    cyc();
    out_rdy = 3'b111;
    for (int k = 0; k < 20 && !took; k++) begin
      @(negedge clk);
      if (in_rdy) took = 1;
      cyc();
    end
    in_val = 0;
    vectors++;
    if (!took) begin
      miscompares++;
      $display("FAIL full_17th got not accepted required accepted");
    end
    wait_empty();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit low = 0;
    out_rdy = 3'b011;
    exp_mask = 3'b111;
    in_val = 1;
    in_bits = 8'h55;
    cyc();
    in_val = 0;
    for (int k = 0; k < 100 && !low; k++) begin
      @(negedge clk);
      if (out_val[2]) n++;
      else low = 1;
    end
    vectors++;
    if (n != TMO) begin
      miscompares++;
      $display("FAIL tmo_cycles got %0d required %0d", n, TMO);
    end
    vectors++;
    if (stalled !== 3'b100 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL tmo_stall got %b lvl %0d required 100 lvl 0", stalled, level);
    end
    if (sq[2].size() != 0) void'(sq[2].pop_front());
    cyc();
    exp_mask = 3'b011;
    in_val = 1;
    in_bits = 8'h56;
    cyc();
    in_val = 0;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b011 || out_bits !== 8'h56) begin
      miscompares++;
      $display("FAIL tmo_masked got %b/%h required 011/56", out_val, out_bits);
    end
    cyc();
    ch_en = 3'b011;
    cyc();
    ch_en = 3'b111;
    @(negedge clk);
    vectors++;
    if (stalled !== 3'b000) begin
      miscompares++;
      $display("FAIL tmo_clear got %b required 000", stalled);
    end
    cyc();
    out_rdy = 3'b111;
    exp_mask = 3'b111;
    in_val = 1;
    in_bits = 8'h57;
    cyc();
    in_val = 0;
    @(negedge clk);
    vectors++;
    if (out_val !== 3'b111) begin
      miscompares++;
      $display("FAIL tmo_rejoin got %b required 111", out_val);
    end
    wait_empty();
  endtask

  task automatic test_drop();
    ch_en = 3'b000;
    exp_mask = 3'b000;
    for (int i = 0; i < 3; i++) begin
      in_val = 1;
      in_bits = 8'hA0 + 8'(i);
      cyc();
    end
    in_val = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (out_val !== 3'b000) begin
        miscompares++;
        $display("FAIL drop_val got %b required 000", out_val);
      end
      cyc();
    end
    wait_empty();
    vectors++;
    if (drop_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL drop_cnt got %0d required 3", drop_cnt);
    end
    in_val = 1;
    repeat (65540) cyc();
    in_val = 0;
    wait_empty();
    vectors++;
    if (drop_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL drop_sat got %h required ffff", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    ch_en = 3'b111;
    exp_mask = 3'b111;
    out_rdy = 3'b000;
    for (int i = 0; i < 5; i++) begin
      in_val = 1;
      in_bits = 8'hC0 + 8'(i);
      cyc();
    end
    in_val = 0;
    @(negedge clk);
    vectors++;
    if (level !== 5'd5 || out_val !== 3'b111) begin
      miscompares++;
      $display("FAIL mid_level got %0d/%b required 5/111", level, out_val);
    end
    cyc();
    rstin = 0;
    #1;
    vectors++;
    if ({level, out_val, stalled, drop_cnt, in_rdy} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got lvl %0d val %b stl %b drop %h rdy %b required all 0",
               level, out_val, stalled, drop_cnt, in_rdy);
    end
    for (int i = 0; i < NCH; i++) sq[i].delete();
    cyc();
    rstin = 1;
    @(negedge clk);
    vectors++;
    if (in_rdy !== 1'b1 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_release got rdy %b lvl %0d required 1/0", in_rdy, level);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_slow_sink();
    test_full();
    test_timeout();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
